// File: rtl/lsu_pkg.sv
`default_nettype none
// lsu_pkg: shared encodings and request-check helpers for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] FUNC3_B  = 3'b000;
  localparam logic [2:0] FUNC3_H  = 3'b001;
  localparam logic [2:0] FUNC3_W  = 3'b010;
  localparam logic [2:0] FUNC3_BU = 3'b100;
  localparam logic [2:0] FUNC3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    NONE       = 2'b00,
    MISALIGNED = 2'b01,
    ILLEGAL    = 2'b10,
    TIMEOUT    = 2'b11
  } fault_cause_t;

  function automatic logic func3_legal(input logic is_load, input logic [2:0] f3);
    if (is_load)
      return (f3 == FUNC3_B) || (f3 == FUNC3_H) || (f3 == FUNC3_W) ||
             (f3 == FUNC3_BU) || (f3 == FUNC3_HU);
    return (f3 == FUNC3_B) || (f3 == FUNC3_H) || (f3 == FUNC3_W);
  endfunction

  // Low two func_3 bits encode the access size for both signed and unsigned forms.
  function automatic logic access_misaligned(input logic [2:0] f3, input logic [1:0] lane);
    case (f3[1:0])
      2'b01:   return lane[0];
      2'b10:   return lane != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_data_aligner.sv
`default_nettype none
// load_data_aligner: picks the addressed byte/halfword out of a read word and extends it.
module load_data_aligner
  import lsu_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  func_3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sign_ext;

  always_comb begin
    byte_sel = mem_rdata[8*lane +: 8];
    half_sel = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    sign_ext = ~func_3[2];
    case (func_3)
      FUNC3_B, FUNC3_BU: result = {{24{byte_sel[7] & sign_ext}}, byte_sel};
      FUNC3_H, FUNC3_HU: result = {{16{half_sel[15] & sign_ext}}, half_sel};
      default:           result = mem_rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// load_store_unit: checks execute-stage load/store requests and runs one valid/ready
// data-memory transaction per accepted request, stalling the core meanwhile.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        store,
  input  logic [2:0]  func_3,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);

  lsu_state_t  state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] count;
  logic [31:0] load_data_q;
  logic        load_valid_q;
  logic        timed_out_q;

  logic        req;
  logic        reject_illegal;
  logic        reject_misaligned;
  logic        accept;
  logic [31:0] fmt_wdata;
  logic [3:0]  fmt_wstrb;
  logic [31:0] aligned;

  // Requests are only examined in IDLE; gating with rst keeps all outputs low in reset.
  always_comb begin
    req               = (load | store) & ~rst & (state == IDLE);
    reject_illegal    = req & ~func3_legal(load, func_3);
    reject_misaligned = req & ~reject_illegal & access_misaligned(func_3, address[1:0]);
    accept            = req & ~reject_illegal & ~reject_misaligned;
  end

  always_comb begin
    case (func_3[1:0])
      2'b00: begin
        fmt_wdata = {4{store_data[7:0]}};
        fmt_wstrb = 4'b0001 << address[1:0];
      end
      2'b01: begin
        fmt_wdata = {2{store_data[15:0]}};
        fmt_wstrb = 4'b0011 << address[1:0];
      end
      default: begin
        fmt_wdata = store_data;
        fmt_wstrb = 4'b1111;
      end
    endcase
  end

  load_data_aligner u_aligner (
    .mem_rdata (mem_rdata),
    .lane      (addr_q[1:0]),
    .func_3    (f3_q),
    .result    (aligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      we_q         <= 1'b0;
      f3_q         <= '0;
      count        <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      timed_out_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // A simultaneous load and store decodes as a load.
            addr_q      <= address;
            we_q        <= ~load;
            f3_q        <= func_3;
            wdata_q     <= load ? 32'd0 : fmt_wdata;
            wstrb_q     <= load ? 4'b0000 : fmt_wstrb;
            count       <= '0;
            timed_out_q <= 1'b0;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            if (!we_q) begin
              load_data_q  <= aligned;
              load_valid_q <= 1'b1;
            end
            state <= DONE;
          end else if ((TIMEOUT_CYCLES != 0) && (count + 32'd1 == TIMEOUT_LIMIT)) begin
            timed_out_q <= 1'b1;
            load_data_q <= '0;
            count       <= count + 32'd1;
            state       <= DONE;
          end else begin
            count <= count + 32'd1;
          end
        end
        DONE: begin
          load_valid_q <= 1'b0;
          timed_out_q  <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    stall      = accept | (state == BUSY);
    mem_valid  = (state == BUSY);
    mem_we     = we_q;
    mem_addr   = {addr_q[31:2], 2'b00};
    mem_wdata  = wdata_q;
    mem_wstrb  = wstrb_q;
    load_data  = load_data_q;
    load_valid = load_valid_q;
    fault      = reject_illegal | reject_misaligned | ((state == DONE) & timed_out_q);
    if (reject_illegal)
      fault_cause = ILLEGAL;
    else if (reject_misaligned)
      fault_cause = MISALIGNED;
    else if ((state == DONE) && timed_out_q)
      fault_cause = TIMEOUT;
    else
      fault_cause = NONE;
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
`timescale 1ns/1ps
// tb_load_store_unit: randomized and directed accesses checked against a behavioural model.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        load, store;
  logic [2:0]  func_3;
  logic [31:0] address, store_data, mem_rdata;
  logic        mem_ready;
  logic        stall, load_valid, fault, mem_valid, mem_we;
  logic [1:0]  fault_cause;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_ld = 32'd0;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .store      (store),
    .func_3     (func_3),
    .address    (address),
    .store_data (store_data),
    .stall      (stall),
    .load_data  (load_data),
    .load_valid (load_valid),
    .fault      (fault),
    .fault_cause(fault_cause),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, want, $time);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  // 2'b10 illegal, 2'b01 misaligned, 2'b00 accepted
  function automatic logic [1:0] reject_of(input logic ld, input logic [2:0] f3,
                                           input logic [1:0] lane);
    logic legal;
    legal = ld ? (f3 != 3'd3 && f3 < 3'd6) : (f3 <= 3'd2);
    if (!legal) return 2'b10;
    if ((int'(lane) % size_of(f3)) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [1:0] lane,
                                             input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * int'(lane));
    case (size_of(f3))
      1:       return f3[2] ? {24'd0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
      2:       return f3[2] ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      default: return rd;
    endcase
  endfunction

  function automatic logic [35:0] store_lanes(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] sd);
    logic [31:0] wd;
    logic [3:0]  ws;
    int          sz;
    sz = size_of(f3);
    for (int k = 0; k < 4; k++) begin
      wd[8*k +: 8] = sd[8*(k % sz) +: 8];
      ws[k]        = (k >= int'(lane)) && (k < int'(lane) + sz);
    end
    return {ws, wd};
  endfunction

  task automatic idle_cycle();
    @(negedge clk);
    load = 1'b0; store = 1'b0; mem_ready = 1'($urandom); address = $urandom;
    func_3 = 3'($urandom); mem_rdata = $urandom;
    #2;
    chk("idle_stall", stall, 0);
    chk("idle_mem_valid", mem_valid, 0);
    chk("idle_fault", fault, 0);
    chk("idle_load_valid", load_valid, 0);
    chk("idle_load_data", load_data, model_ld);
  endtask

  task automatic access(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sd,
                        input logic [31:0] rd, input int delay,
                        input logic lit_en, input logic [31:0] lit);
    logic [1:0]  rej;
    logic        is_ld, timed_out;
    logic [35:0] lanes;
    is_ld = ld;
    rej   = reject_of(is_ld, f3, addr[1:0]);
    lanes = store_lanes(f3, addr[1:0], sd);
    @(negedge clk);
    load = ld; store = st; func_3 = f3; address = addr; store_data = sd;
    mem_ready = 1'b0; mem_rdata = $urandom;
    #2;
    chk("req_stall", stall, 32'(rej == 2'b00));
    chk("req_fault", fault, 32'(rej != 2'b00));
    chk("req_cause", fault_cause, rej);
    chk("req_mem_valid", mem_valid, 0);
    chk("req_load_valid", load_valid, 0);
    chk("req_load_data", load_data, model_ld);
    if (rej != 2'b00) begin
      @(negedge clk);
      load = 1'b0; store = 1'b0;
      return;
    end
    timed_out = 1'b0;
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      load = 1'b0; store = 1'b0;
      address = $urandom; func_3 = 3'($urandom); store_data = $urandom;
      mem_ready = (i >= delay);
      mem_rdata = (i >= delay) ? rd : $urandom;
      #2;
      chk("busy_mem_valid", mem_valid, 1);
      chk("busy_stall", stall, 1);
      chk("busy_fault", fault, 0);
      chk("busy_load_valid", load_valid, 0);
      chk("busy_mem_addr", mem_addr, {addr[31:2], 2'b00});
      chk("busy_mem_we", mem_we, 32'(!is_ld));
      chk("busy_mem_wstrb", mem_wstrb, is_ld ? 4'b0000 : lanes[35:32]);
      if (!is_ld) chk("busy_mem_wdata", mem_wdata, lanes[31:0]);
      if (lit_en && !is_ld) chk("lit_mem_wdata", mem_wdata, lit);
      if (mem_ready) break;
      if (i == TO - 1) timed_out = 1'b1;
    end
    @(negedge clk);
    mem_ready = 1'($urandom); mem_rdata = $urandom;
    if (timed_out) model_ld = 32'd0;
    else if (is_ld) model_ld = load_value(f3, addr[1:0], rd);
    #2;
    chk("done_stall", stall, 0);
    chk("done_mem_valid", mem_valid, 0);
    chk("done_load_valid", load_valid, 32'(is_ld && !timed_out));
    chk("done_fault", fault, 32'(timed_out));
    chk("done_cause", fault_cause, timed_out ? 2'b11 : 2'b00);
    chk("done_load_data", load_data, model_ld);
    if (lit_en && is_ld) chk("lit_load_data", load_data, lit);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_mem_valid"}, mem_valid, 0);
    chk({tag, "_load_valid"}, load_valid, 0);
    chk({tag, "_load_data"}, load_data, 0);
    chk({tag, "_fault"}, fault, 0);
    chk({tag, "_cause"}, fault_cause, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_mem_wstrb"}, mem_wstrb, 0);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; store = 1'b0; func_3 = 3'd0; address = 32'd0;
    store_data = 32'd0; mem_rdata = 32'd0; mem_ready = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    access(1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_7F01, 0, 1, 32'hFFFF_FF80);
    access(1, 0, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 0, 1, 32'h0000_BEEF);
    access(1, 0, 3'b001, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 1, 1, 32'hFFFF_BEEF);
    access(0, 1, 3'b000, 32'h0000_3001, 32'h1234_56AB, 32'h0, 3, 1, 32'hABAB_ABAB);
    idle_cycle();
    access(0, 1, 3'b010, 32'h0000_4002, 32'hDEAD_BEEF, 32'h0, 0, 0, 32'h0);
    access(1, 0, 3'b011, 32'h0000_4000, 32'h0, 32'h0, 0, 0, 32'h0);
    access(1, 0, 3'b010, 32'h0000_5000, 32'h0, 32'h1111_2222, 10, 0, 32'h0);
    access(1, 1, 3'b100, 32'h0000_6001, 32'hCAFE_F00D, 32'h0012_8300, 0, 1, 32'h0000_0083);

    // Reset while an SW is waiting on the bus.
    @(negedge clk);
    load = 1'b0; store = 1'b1; func_3 = 3'b010; address = 32'h0000_7000;
    store_data = 32'h5A5A_A5A5; mem_ready = 1'b0;
    #2;
    chk("rst_req_stall", stall, 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      store = 1'b0;
      #2;
      chk("rst_busy_mem_valid", mem_valid, 1);
    end
    #1 rst = 1'b1;
    #1;
    model_ld = 32'd0;
    check_all_zero("midreset");
    @(negedge clk);
    rst = 1'b0;
    access(1, 0, 3'b010, 32'h0000_8004, 32'h0, 32'h0BAD_CAFE, 1, 1, 32'h0BAD_CAFE);

    for (int n = 0; n < 300; n++) begin
      int          kind;
      logic [2:0]  f3;
      logic [31:0] a;
      kind = int'($urandom_range(0, 4));
      f3   = ($urandom_range(0, 9) < 7) ? 3'($urandom_range(0, 2)) : 3'($urandom);
      if (kind == 0 && $urandom_range(0, 1) == 1) f3 = 3'($urandom_range(4, 5));
      a    = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'(int'(a[1:0]) & ~(size_of(f3) - 1));
      case (kind)
        0, 1:    access(1, 0, f3, a, $urandom, $urandom, int'($urandom_range(0, 5)), 0, 32'h0);
        2:       access(0, 1, f3, a, $urandom, $urandom, int'($urandom_range(0, 5)), 0, 32'h0);
        3:       access(1, 1, f3, a, $urandom, $urandom, int'($urandom_range(0, 5)), 0, 32'h0);
        default: idle_cycle();
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
